alu_exec_stage: RTL and testbench

Execute-stage wrapper that sits directly upstream of the combinational alu and feeds it. It accepts decoded operations from decode over a valid/ready handshake and captures the operands into a pipeline register. It drives the alu from those captured values and presents the result with its destination register to writeback over a second valid/ready handshake. Multiply (op 5) is given a configurable multi-cycle latency so the 32x32 multiplier can be retimed without changing timing at the block boundary.

---
 rtl/alu_exec_stage.sv | 75 +++++++
 tb/tb_alu_exec_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage wrapper that captures decoded ops, feeds the alu and hands results to writeback
module alu (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = op == 3'd0 ? a | b :
            op == 3'd1 ? a & b :
            op == 3'd2 ? a ^ b :
            op == 3'd3 ? a + b :
            op == 3'd4 ? a - b :
            op == 3'd5 ? a * b : 32'd0;
    end
endmodule

module alu_exec_stage #(
    parameter int MUL_LAT = 3,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_illegal
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  cnt;
    logic        accept;
    assign in_ready  = !rst && (state == IDLE || (state == HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state == HOLD;
    alu u_alu (.op(op_q), .a(a_q), .b(b_q), .y(out_result));
    // A new op may be accepted in the same edge that retires the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
            cnt         <= '0;
        end else if (accept) begin
            op_q        <= in_op;
            a_q         <= in_a;
            b_q         <= in_b;
            out_rd      <= in_rd;
            out_illegal <= in_op[2:1] == 2'b11;
            if (in_op == 3'd5 && MUL_LAT > 1) begin
                state <= MUL;
                cnt   <= 4'(MUL_LAT - 1);
            end else begin
                state <= HOLD;
            end
        end else if (state == MUL) begin
            cnt   <= cnt - 4'd1;
            state <= cnt == 4'd1 ? HOLD : MUL;
        end else if (state == HOLD && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed self-checking bench for alu_exec_stage with MUL_LAT=3
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic [4:0]  in_rd, out_rd;
    int          n_checks = 0;
    int          n_fail = 0;

    alu_exec_stage #(.MUL_LAT(3), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'd3, 32'd1, 32'd2, 5'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({in_ready, out_valid, out_rd, out_result} !== 39'd0) begin
                $display("FAIL reset[%0d]: got rdy=%b vld=%b rd=%0d res=%h, expected all 0", i, in_ready, out_valid, out_rd, out_result);
                n_fail++;
            end
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1'b1, 3'd3, 32'hFFFFFFFF, 32'd1, 5'd3);
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd3, 32'h00000000}) begin
            $display("FAIL b2b_add: got vld=%b rd=%0d res=%h, expected 1/3/00000000", out_valid, out_rd, out_result);
            n_fail++;
        end
        drive(1'b1, 3'd4, 32'd5, 32'd7, 5'd4);
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd4, 32'hFFFFFFFE}) begin
            $display("FAIL b2b_sub: got vld=%b rd=%0d res=%h, expected 1/4/fffffffe", out_valid, out_rd, out_result);
            n_fail++;
        end
        drive(1'b1, 3'd2, 32'hF0F0F0F0, 32'hFFFF0000, 5'd5);
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_result, out_illegal} !== {1'b1, 5'd5, 32'h0F0FF0F0, 1'b0}) begin
            $display("FAIL b2b_xor: got vld=%b rd=%0d res=%h ill=%b, expected 1/5/0f0ff0f0/0", out_valid, out_rd, out_result, out_illegal);
            n_fail++;
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_drain: got vld=%b, expected 0", out_valid);
            n_fail++;
        end
    endtask

    task automatic test_mul;
        out_ready = 1'b1;
        drive(1'b1, 3'd5, 32'h10000, 32'h10000, 5'd7);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                $display("FAIL mul1_wait[%0d]: got vld=%b rdy=%b, expected 0/0", i, out_valid, in_ready);
                n_fail++;
            end
            tick();
        end
        n_checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd7, 32'h00000000}) begin
            $display("FAIL mul1_result: got vld=%b rd=%0d res=%h, expected 1/7/00000000", out_valid, out_rd, out_result);
            n_fail++;
        end
        drive(1'b1, 3'd5, 32'd7, 32'd6, 5'd8);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                $display("FAIL mul2_wait[%0d]: got vld=%b rdy=%b, expected 0/0", i, out_valid, in_ready);
                n_fail++;
            end
            tick();
        end
        n_checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd8, 32'd42}) begin
            $display("FAIL mul2_result: got vld=%b rd=%0d res=%h, expected 1/8/0000002a", out_valid, out_rd, out_result);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h0F, 32'hF0, 5'd9);
        tick();
        drive(1'b1, 3'd1, 32'd2, 32'd3, 5'd10);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({out_valid, in_ready, out_rd, out_result} !== {1'b1, 1'b0, 5'd9, 32'hFF}) begin
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b rd=%0d res=%h, expected 1/0/9/000000ff", i, out_valid, in_ready, out_rd, out_result);
                n_fail++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_ready: got rdy=%b, expected 1", in_ready);
            n_fail++;
        end
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd10, 32'd2}) begin
            $display("FAIL bp_next: got vld=%b rd=%0d res=%h, expected 1/10/00000002", out_valid, out_rd, out_result);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        drive(1'b1, 3'd6, 32'd5, 32'd5, 5'd11);
        tick();
        n_checks++;
        if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b1, 5'd11, 32'd0}) begin
            $display("FAIL illegal_op6: got vld=%b ill=%b rd=%0d res=%h, expected 1/1/11/00000000", out_valid, out_illegal, out_rd, out_result);
            n_fail++;
        end
        drive(1'b1, 3'd3, 32'd5, 32'd5, 5'd12);
        tick();
        n_checks++;
        if ({out_valid, out_illegal, out_rd, out_result} !== {1'b1, 1'b0, 5'd12, 32'd10}) begin
            $display("FAIL illegal_after: got vld=%b ill=%b rd=%0d res=%h, expected 1/0/12/0000000a", out_valid, out_illegal, out_rd, out_result);
            n_fail++;
        end
        drive(1'b1, 3'd7, 32'hFFFF, 32'h1, 5'd13);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({out_valid, out_illegal, out_result} !== {1'b1, 1'b1, 32'd0}) begin
            $display("FAIL illegal_op7: got vld=%b ill=%b res=%h, expected 1/1/00000000", out_valid, out_illegal, out_result);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_reset_mid_mul;
        out_ready = 1'b1;
        drive(1'b1, 3'd5, 32'd3, 32'd3, 5'd13);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({out_valid, out_rd, out_result} !== 38'd0) begin
                $display("FAIL rst_mul[%0d]: got vld=%b rd=%0d res=%h, expected 0/0/00000000", i, out_valid, out_rd, out_result);
                n_fail++;
            end
            tick();
        end
        drive(1'b1, 3'd3, 32'd1, 32'd1, 5'd14);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd14, 32'd2}) begin
            $display("FAIL rst_mul_add: got vld=%b rd=%0d res=%h, expected 1/14/00000002", out_valid, out_rd, out_result);
            n_fail++;
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        test_reset();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
